// File: rtl/pkt_capture.sv
// pkt_capture: ingress stage of the capture path. Packs a byte stream
// little-endian into 32-bit words for the capture FIFO. Places each finished
// packet in the circular host buffer and hands that placement to the
// downstream write controller.

// One byte lane of the packing word. It holds the byte stored at this lane
// position and supplies this lane's share of the word being completed.
module pkt_capture_lane #(
  parameter int LANE = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       store,
  input  logic [1:0] cur,
  input  logic [7:0] din,
  output logic [7:0] word_byte
);
  logic [7:0] byte_q;

  // capture the incoming byte when it targets this lane
  always_ff @(posedge clk) begin
    if (reset) byte_q <= '0;
    else if (store && cur == 2'(LANE)) byte_q <= din;
  end

  // Lanes below the current one supply their stored bytes.
  // The current lane takes the live byte; lanes above it are zero padding.
  always_comb begin
    word_byte = '0;
    if (cur == 2'(LANE)) word_byte = din;
    else if (cur > 2'(LANE)) word_byte = byte_q;
  end
endmodule

module pkt_capture #(
  parameter int MAX_PKT_BYTES = 1520
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] buf_base,
  input  logic [31:0] buf_size,
  input  logic [7:0]  st_data,
  input  logic        st_valid,
  input  logic        st_sop,
  input  logic        st_eop,
  output logic        st_ready,
  output logic [31:0] fifo_in,
  output logic        wr_to_fifo,
  input  logic        full,
  output logic        wr_ctrl,
  input  logic        wr_ctrl_rdy,
  output logic [31:0] pkt_begin,
  output logic [31:0] pkt_end,
  output logic [31:0] write_address,
  output logic [31:0] pkt_count,
  output logic [15:0] drop_count,
  output logic        trunc
);
  localparam int          NUM_LANES = 4;
  localparam logic [15:0] MAX_LEN   = 16'(MAX_PKT_BYTES);

  typedef enum logic [2:0] {
    IDLE, CAPTURE, DISCARD, FLUSH, HANDOFF, WAIT_DONE
  } state_t;

  state_t state, state_nxt;

  logic [15:0]                 len;
  logic                        pending;
  logic [31:0]                 wr_ptr;
  logic                        accept;
  logic                        store;
  logic                        room;
  logic                        word_done;
  logic [1:0]                  cur;
  logic [NUM_LANES-1:0][7:0]   word_nxt;
  logic [31:0]                 padded;
  logic [31:0]                 place_ptr;

  assign accept = st_valid && st_ready;
  assign room   = (len < MAX_LEN);
  // The sop byte always lands in lane 0. Later bytes follow the running length.
  assign cur    = (state == CAPTURE) ? len[1:0] : 2'd0;
  assign store  = accept && ((state == IDLE && st_sop && enable) ||
                             (state == CAPTURE && room));
  // A word is complete when lane 3 fills or when eop ends a partial word.
  // A truncated eop stores nothing, so no extra word is created.
  assign word_done = store && (cur == 2'd3 || st_eop);

  assign padded    = ({16'd0, len} + 32'd3) & ~32'd3;
  // A packet is never split across the end of the buffer: wrap first.
  assign place_ptr = (wr_ptr + padded > buf_size) ? 32'd0 : wr_ptr;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    pkt_capture_lane #(.LANE(i)) u_lane (
      .clk       (clk),
      .reset     (reset),
      .store     (store),
      .cur       (cur),
      .din       (st_data),
      .word_byte (word_nxt[i])
    );
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // stream and FIFO handshake outputs, decoded from state and pending word
  always_comb begin
    st_ready   = 1'b0;
    wr_to_fifo = pending && !full;
    case (state)
      IDLE, DISCARD: st_ready = 1'b1;
      CAPTURE:       st_ready = !full && !pending;
      default:       st_ready = 1'b0;
    endcase
    if (reset) st_ready = 1'b0;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && st_sop) begin
          if (enable) state_nxt = st_eop ? FLUSH : CAPTURE;
          else        state_nxt = st_eop ? IDLE  : DISCARD;
        end
      end
      CAPTURE:   if (accept && st_eop) state_nxt = FLUSH;
      DISCARD:   if (accept && st_eop) state_nxt = IDLE;
      // Leave as soon as the last word is written this cycle; do not wait a cycle.
      FLUSH:     if (!pending || !full) state_nxt = HANDOFF;
      HANDOFF:   state_nxt = WAIT_DONE;
      WAIT_DONE: if (wr_ctrl_rdy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // word packing, length tracking, truncation and drop statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      len        <= '0;
      pending    <= 1'b0;
      fifo_in    <= '0;
      trunc      <= 1'b0;
      drop_count <= '0;
    end else begin
      if (word_done) begin
        fifo_in <= word_nxt;
        pending <= 1'b1;
      end else if (wr_to_fifo) begin
        pending <= 1'b0;
      end
      if (state == IDLE && store)         len <= 16'd1;
      else if (state == CAPTURE && store) len <= len + 16'd1;
      if (state == CAPTURE && accept && !room) trunc <= 1'b1;
      if (state == IDLE && accept && st_sop && !enable && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
    end
  end

  // buffer placement, write-controller handshake and packet count
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      pkt_begin     <= '0;
      pkt_end       <= '0;
      write_address <= '0;
      pkt_count     <= '0;
      wr_ctrl       <= 1'b0;
    end else begin
      wr_ctrl <= (state == HANDOFF);
      if (state == HANDOFF) begin
        wr_ptr        <= place_ptr;
        pkt_begin     <= place_ptr;
        pkt_end       <= place_ptr + padded;
        write_address <= buf_base + place_ptr;
      end
      if (state == WAIT_DONE && wr_ctrl_rdy) begin
        wr_ptr    <= wr_ptr + padded;
        pkt_count <= pkt_count + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_pkt_capture.sv
// Bench for pkt_capture: directed scenarios plus randomized packets checked
// against a packet-level model (word list, padded length, buffer placement).
module tb_pkt_capture;
  localparam int MAX = 1520;

  logic        clk = 0;
  logic        reset = 1;
  logic        enable = 0;
  logic [31:0] buf_base = 0;
  logic [31:0] buf_size = 0;
  logic [7:0]  st_data = 0;
  logic        st_valid = 0, st_sop = 0, st_eop = 0;
  logic        full = 0, wr_ctrl_rdy = 0;
  logic        st_ready, wr_to_fifo, wr_ctrl, trunc;
  logic [31:0] fifo_in, pkt_begin, pkt_end, write_address, pkt_count;
  logic [15:0] drop_count;

  int total = 0, bad = 0;
  int cyc = 0;
  int ctrl_cnt = 0;
  int last_wr_cyc = 0;
  int acc_cyc = 0, ctrl_lat = 0, wr_lat = 0;
  int hold_at = -1;
  bit rand_mode = 0;
  logic [31:0] got_q[$];
  logic [7:0]  tx_q[$];

  // model state
  logic [31:0] m_ptr = 0, m_count = 0;
  logic [15:0] m_drop = 0;
  logic        m_trunc = 0;

  pkt_capture #(.MAX_PKT_BYTES(MAX)) dut (
    .clk(clk), .reset(reset), .enable(enable), .buf_base(buf_base), .buf_size(buf_size),
    .st_data(st_data), .st_valid(st_valid), .st_sop(st_sop), .st_eop(st_eop),
    .st_ready(st_ready), .fifo_in(fifo_in), .wr_to_fifo(wr_to_fifo), .full(full),
    .wr_ctrl(wr_ctrl), .wr_ctrl_rdy(wr_ctrl_rdy), .pkt_begin(pkt_begin), .pkt_end(pkt_end),
    .write_address(write_address), .pkt_count(pkt_count), .drop_count(drop_count), .trunc(trunc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO and write-controller monitor
  always @(negedge clk) begin
    if (wr_to_fifo) begin
      got_q.push_back(fifo_in);
      last_wr_cyc = cyc;
    end
    if (wr_ctrl) ctrl_cnt++;
  end

  task automatic fill_seq(input logic [7:0] start, input int n);
    tx_q.delete();
    for (int i = 0; i < n; i++) tx_q.push_back(8'(start + i));
  endtask

  task automatic fill_rand(input int n);
    tx_q.delete();
    for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
  endtask

  task automatic send_byte(input logic [7:0] d, input logic sop, input logic eop);
    bit done = 0;
    st_data = d; st_sop = sop; st_eop = eop; st_valid = 1;
    for (int t = 0; t < 400 && !done; t++) begin
      if (rand_mode) full = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      if (st_ready) begin
        done = 1;
        acc_cyc = cyc;
      end
      @(posedge clk); #1;
    end
    st_valid = 0; st_sop = 0; st_eop = 0;
    if (!done) begin
      total++; bad++;
      $display("FAIL byte_accept: byte %h never accepted", d);
    end
  endtask

  // Drive one packet from tx_q, model its placement, and check words and handoff.
  task automatic do_packet(input bit en, input string name);
    int n, nst, pad, w0, c0, nw, k;
    bit seen;
    logic [31:0] exp_w;
    n = tx_q.size();
    w0 = got_q.size();
    c0 = ctrl_cnt;
    for (int i = 0; i < n; i++) begin
      enable = (i == 0 || !rand_mode) ? en : 1'($urandom_range(0, 1));
      send_byte(tx_q[i], i == 0, i == n - 1);
      if (i == hold_at) begin
        full = 1;
        for (int h = 0; h < 10; h++) begin
          @(negedge clk);
          total++;
          if (st_ready !== 1'b0 || wr_to_fifo !== 1'b0) begin
            bad++;
            $display("FAIL %s_hold: st_ready=%b wr_to_fifo=%b, need 0 0", name, st_ready, wr_to_fifo);
          end
          @(posedge clk); #1;
        end
        full = 0;
        @(negedge clk);
        exp_w = {tx_q[i], tx_q[i-1], tx_q[i-2], tx_q[i-3]};
        total++;
        if (wr_to_fifo !== 1'b1 || fifo_in !== exp_w) begin
          bad++;
          $display("FAIL %s_release: wr_to_fifo=%b fifo_in=%h, need 1 %h", name, wr_to_fifo, fifo_in, exp_w);
        end
        @(posedge clk); #1;
      end
    end
    enable = en;

    if (!en) begin
      m_drop = (m_drop == 16'hFFFF) ? m_drop : m_drop + 16'd1;
      repeat (4) @(posedge clk);
      #1;
      total++;
      if (got_q.size() != w0 || ctrl_cnt != c0) begin
        bad++;
        $display("FAIL %s_nowrite: words=%0d pulses=%0d, need 0 0", name, got_q.size() - w0, ctrl_cnt - c0);
      end
      total++;
      if (drop_count !== m_drop) begin
        bad++;
        $display("FAIL %s_drop_count: got %0d need %0d", name, drop_count, m_drop);
      end
      return;
    end

    nst = (n > MAX) ? MAX : n;
    pad = ((nst + 3) / 4) * 4;
    if (n > MAX) m_trunc = 1;
    if (m_ptr + 32'(pad) > buf_size) m_ptr = 0;

    seen = 0;
    for (int t = 0; t < 400 && !seen; t++) begin
      if (rand_mode) full = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      if (wr_ctrl === 1'b1) begin
        seen = 1;
        ctrl_lat = cyc - acc_cyc;
        wr_lat = last_wr_cyc - acc_cyc;
        total++;
        if (pkt_begin !== m_ptr || pkt_end !== m_ptr + 32'(pad) || write_address !== buf_base + m_ptr) begin
          bad++;
          $display("FAIL %s_place: begin=%h end=%h addr=%h, need %h %h %h", name, pkt_begin, pkt_end,
                   write_address, m_ptr, m_ptr + 32'(pad), buf_base + m_ptr);
        end
      end
      @(posedge clk); #1;
    end
    full = 0;
    if (!seen) begin
      total++; bad++;
      $display("FAIL %s_wr_ctrl: no pulse within budget", name);
    end

    nw = pad / 4;
    total++;
    if (got_q.size() - w0 != nw) begin
      bad++;
      $display("FAIL %s_word_count: got %0d need %0d", name, got_q.size() - w0, nw);
    end else begin
      for (int w = 0; w < nw; w++) begin
        exp_w = 0;
        for (int b = 0; b < 4; b++)
          if (4 * w + b < nst) exp_w[8*b +: 8] = tx_q[4*w+b];
        total++;
        if (got_q[w0+w] !== exp_w) begin
          bad++;
          $display("FAIL %s_word%0d: got %h need %h", name, w, got_q[w0+w], exp_w);
        end
      end
    end

    total++;
    if (wr_ctrl !== 1'b0) begin
      bad++;
      $display("FAIL %s_pulse_width: wr_ctrl=%b still high, need 0", name, wr_ctrl);
    end

    k = rand_mode ? $urandom_range(0, 3) : 0;
    repeat (k) begin @(posedge clk); #1; end
    wr_ctrl_rdy = 1;
    @(posedge clk); #1;
    wr_ctrl_rdy = 0;
    m_ptr = m_ptr + 32'(pad);
    m_count = m_count + 1;
    total++;
    if (pkt_count !== m_count || ctrl_cnt - c0 != 1 || trunc !== m_trunc) begin
      bad++;
      $display("FAIL %s_stats: pkt_count=%0d pulses=%0d trunc=%b, need %0d 1 %b", name, pkt_count,
               ctrl_cnt - c0, trunc, m_count, m_trunc);
    end
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({st_ready, wr_to_fifo, wr_ctrl, trunc, fifo_in, pkt_begin, pkt_end, write_address,
         pkt_count, drop_count} !== '0) begin
      bad++;
      $display("FAIL reset_values: rdy=%b wr=%b ctrl=%b trunc=%b fifo=%h beg=%h end=%h addr=%h cnt=%0d drop=%0d, need all 0",
               st_ready, wr_to_fifo, wr_ctrl, trunc, fifo_in, pkt_begin, pkt_end, write_address, pkt_count, drop_count);
    end
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    total++;
    if (st_ready !== 1'b1) begin
      bad++;
      $display("FAIL idle_ready: st_ready=%b need 1", st_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    buf_base = 32'h1000; buf_size = 32'h100; enable = 1;
    fill_seq(8'h01, 8);
    do_packet(1, "basic");
    total++;
    if (pkt_begin !== 32'd0 || pkt_end !== 32'd8 || write_address !== 32'h1000) begin
      bad++;
      $display("FAIL basic_const: begin=%h end=%h addr=%h, need 0 8 1000", pkt_begin, pkt_end, write_address);
    end
    total++;
    if (ctrl_lat != 3 || wr_lat != 1) begin
      bad++;
      $display("FAIL basic_latency: wr_ctrl at +%0d last write at +%0d, need +3 +1", ctrl_lat, wr_lat);
    end
    fill_seq(8'h11, 8);
    do_packet(1, "basic2");
    total++;
    if (pkt_begin !== 32'd8) begin
      bad++;
      $display("FAIL basic2_begin: got %0d need 8", pkt_begin);
    end
  endtask

  task automatic test_pad;
    fill_seq(8'hA1, 5);
    do_packet(1, "pad");
    total++;
    if (pkt_end - pkt_begin !== 32'd8) begin
      bad++;
      $display("FAIL pad_len: got %0d need 8", pkt_end - pkt_begin);
    end
  endtask

  task automatic test_backpressure;
    fill_seq(8'h21, 12);
    hold_at = 7;
    do_packet(1, "bp");
    hold_at = -1;
  endtask

  task automatic test_wrap;
    buf_size = 32'd16;
    fill_seq(8'h31, 12);
    do_packet(1, "wrap_fill");
    fill_seq(8'h41, 8);
    do_packet(1, "wrap");
    total++;
    if (pkt_begin !== 32'd0 || pkt_end !== 32'd8 || write_address !== buf_base) begin
      bad++;
      $display("FAIL wrap_const: begin=%h end=%h addr=%h, need 0 8 %h", pkt_begin, pkt_end, write_address, buf_base);
    end
    fill_seq(8'h51, 4);
    do_packet(1, "wrap_after");
    total++;
    if (pkt_begin !== 32'd8) begin
      bad++;
      $display("FAIL wrap_ptr: begin=%0d need 8", pkt_begin);
    end
    buf_size = 32'h100;
  endtask

  task automatic test_drop;
    wr_ctrl_rdy = 1;
    @(posedge clk); #1;
    wr_ctrl_rdy = 0;
    total++;
    if (pkt_count !== m_count) begin
      bad++;
      $display("FAIL stray_rdy: pkt_count=%0d need %0d", pkt_count, m_count);
    end
    fill_seq(8'h61, 6);
    do_packet(0, "drop");
    total++;
    if (drop_count !== 16'd1) begin
      bad++;
      $display("FAIL drop_first: drop_count=%0d need 1", drop_count);
    end
    enable = 1;
  endtask

  task automatic test_trunc;
    buf_size = 32'h1000;
    fill_rand(MAX + 6);
    do_packet(1, "trunc");
    total++;
    if (pkt_end - pkt_begin !== 32'(MAX) || trunc !== 1'b1) begin
      bad++;
      $display("FAIL trunc_len: len=%0d trunc=%b, need %0d 1", pkt_end - pkt_begin, trunc, MAX);
    end
  endtask

  task automatic test_random;
    rand_mode = 1;
    buf_base = {$urandom_range(0, 32'hFFFF), 2'b00};
    buf_size = 32'h80;
    for (int p = 0; p < 24; p++) begin
      if ($urandom_range(0, 3) == 0) send_byte(8'($urandom), 0, 0);
      fill_rand($urandom_range(1, 40));
      do_packet($urandom_range(0, 4) != 0, "rand");
    end
    rand_mode = 0;
    full = 0;
    enable = 1;
    buf_size = 32'h100;
  endtask

  task automatic test_reset_mid;
    enable = 1;
    send_byte(8'h71, 1, 0);
    send_byte(8'h72, 0, 0);
    send_byte(8'h73, 0, 0);
    reset = 1;
    @(negedge clk);
    total++;
    if (st_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready: st_ready=%b need 0", st_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if ({wr_to_fifo, wr_ctrl, trunc, fifo_in, pkt_begin, pkt_end, write_address, pkt_count,
         drop_count} !== '0) begin
      bad++;
      $display("FAIL reset_mid_values: wr=%b ctrl=%b trunc=%b fifo=%h beg=%h end=%h addr=%h cnt=%0d drop=%0d, need all 0",
               wr_to_fifo, wr_ctrl, trunc, fifo_in, pkt_begin, pkt_end, write_address, pkt_count, drop_count);
    end
    @(posedge clk); #1;
    reset = 0;
    m_ptr = 0; m_count = 0; m_drop = 0; m_trunc = 0;
    fill_seq(8'h81, 4);
    do_packet(1, "post_reset");
    total++;
    if (pkt_begin !== 32'd0) begin
      bad++;
      $display("FAIL post_reset_begin: got %0d need 0", pkt_begin);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pad();
    test_backpressure();
    test_wrap();
    test_drop();
    test_trunc();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
